// File: rtl/tmr_wb_master_pkg.sv
// Shared command codes, slave register map, FSM encoding and beat payload for tmr_wb_master.
// The beat helper maps a command and beat index onto one WISHBONE access.
package tmr_wb_master_pkg;

  localparam int unsigned ADR_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 2;
  localparam int unsigned IDX_W  = 2;

  localparam logic [CMD_W-1:0] CMD_RD_US = 2'b00;
  localparam logic [CMD_W-1:0] CMD_RD_MS = 2'b01;
  localparam logic [CMD_W-1:0] CMD_WR    = 2'b10;
  localparam logic [CMD_W-1:0] CMD_BLK   = 2'b11;

  localparam logic [ADR_W-1:0] US_BASE     = 3'd0;
  localparam logic [ADR_W-1:0] MS_BASE     = 3'd4;
  localparam logic [ADR_W-1:0] PWM_ENA_ADR = 3'd6;
  localparam logic [ADR_W-1:0] BLK_ADR     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STB  = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic              we;
    logic [BYTE_W-1:0] dat;
  } beat_t;

  // Address/direction/data driven for beat idx of a command; reads always drive zero data.
  function automatic beat_t beat_of(input logic [CMD_W-1:0]  cmd,
                                    input logic [IDX_W-1:0]  idx,
                                    input logic [ADR_W-1:0]  wadr,
                                    input logic [BYTE_W-1:0] wdat);
    beat_t b;
    b = '0;
    case (cmd)
      CMD_RD_US: b.adr = US_BASE + ADR_W'(idx);
      CMD_RD_MS: b.adr = MS_BASE + ADR_W'(idx);
      CMD_WR: begin
        b.adr = wadr;
        b.we  = 1'b1;
        b.dat = wdat;
      end
      default: begin
        b.adr = BLK_ADR;
        b.we  = 1'b1;
        b.dat = wdat;
      end
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tmr_wb_master_wb8_beat.sv
// Single strobe/ack beat tracker: flags the acknowledged beat or a wait that exceeded TIMEOUT.
// The wait counter idles at zero whenever strobe is low, so every beat starts fresh.
module wb8_beat #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic ack,
  input  logic tmo_en,
  output logic hit_c,
  output logic tmo_c
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!stb || ack) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(TIMEOUT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // An ack in the final allowed cycle still wins over the abort.
  assign hit_c = stb & ack;
  assign tmo_c = stb & ~ack & tmo_en & (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/tmr_wb_master.sv
// WISHBONE master sequencer for the timer/PWM slave: 32-bit counter reads as four
// byte beats (byte 0 first), single register writes, and CPU-blocking delay writes.
module tmr_wb_master
  import tmr_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_i,
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic [ADR_W-1:0]  wadr_i,
  input  logic [BYTE_W-1:0] wdat_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       data_o,
  output logic [ADR_W-1:0]  wb_adr_o,
  output logic [BYTE_W-1:0] wb_dat_o,
  input  logic [BYTE_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i
);

  state_t             state, state_nxt;
  logic [CMD_W-1:0]   cmd_q, cmd_nxt;
  logic [ADR_W-1:0]   wadr_q, wadr_nxt;
  logic [BYTE_W-1:0]  wdat_q, wdat_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               err_q, err_nxt;
  logic [23:0]        shadow, shadow_nxt;
  logic [31:0]        data_nxt;
  beat_t              beat_nxt;
  logic               is_rd, last_beat, hit, tmo;

  assign is_rd     = ~cmd_q[1];
  assign last_beat = ~is_rd | (idx == IDX_W'(3));

  wb8_beat #(.TIMEOUT(TIMEOUT)) u_beat (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .stb    (wb_stb_o),
    .ack    (wb_ack_i),
    .tmo_en (cmd_q != CMD_BLK),
    .hit_c  (hit),
    .tmo_c  (tmo)
  );

  // Next-state, command latch, shadow capture and next beat fields.
  always_comb begin
    state_nxt  = state;
    cmd_nxt    = cmd_q;
    wadr_nxt   = wadr_q;
    wdat_nxt   = wdat_q;
    idx_nxt    = idx;
    err_nxt    = err_q;
    shadow_nxt = shadow;
    data_nxt   = data_o;

    case (state)
      ST_IDLE, ST_FIN: begin
        state_nxt = ST_IDLE;
        if (req_i) begin
          state_nxt = ST_STB;
          cmd_nxt   = cmd_i;
          wadr_nxt  = wadr_i;
          wdat_nxt  = wdat_i;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      ST_STB: begin
        if (hit) begin
          if (is_rd) begin
            case (idx)
              2'd0:    shadow_nxt[7:0]   = wb_dat_i;
              2'd1:    shadow_nxt[15:8]  = wb_dat_i;
              2'd2:    shadow_nxt[23:16] = wb_dat_i;
              default: data_nxt          = {wb_dat_i, shadow};
            endcase
          end
          state_nxt = last_beat ? ST_FIN : ST_GAP;
        end else if (tmo) begin
          state_nxt = ST_FIN;
          err_nxt   = 1'b1;
        end
      end
      ST_GAP: begin
        idx_nxt   = idx + IDX_W'(1);
        state_nxt = ST_STB;
      end
      default: state_nxt = ST_IDLE;
    endcase

    beat_nxt = beat_of(cmd_nxt, idx_nxt, wadr_nxt, wdat_nxt);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      wadr_q   <= '0;
      wdat_q   <= '0;
      idx      <= '0;
      err_q    <= 1'b0;
      shadow   <= '0;
      data_o   <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd_q    <= cmd_nxt;
      wadr_q   <= wadr_nxt;
      wdat_q   <= wdat_nxt;
      idx      <= idx_nxt;
      err_q    <= err_nxt;
      shadow   <= shadow_nxt;
      data_o   <= data_nxt;
      busy_o   <= (state_nxt == ST_STB) || (state_nxt == ST_GAP);
      wb_cyc_o <= (state_nxt == ST_STB) || (state_nxt == ST_GAP);
      wb_stb_o <= (state_nxt == ST_STB);
      done_o   <= (state_nxt == ST_FIN);
      err_o    <= (state_nxt == ST_FIN) && err_nxt;
      // Bus fields are only non-zero while a strobe is presented.
      if (state_nxt == ST_STB) begin
        wb_adr_o <= beat_nxt.adr;
        wb_we_o  <= beat_nxt.we;
        wb_dat_o <= beat_nxt.dat;
      end else begin
        wb_adr_o <= '0;
        wb_we_o  <= 1'b0;
        wb_dat_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmr_wb_master.sv
// Directed bench for tmr_wb_master against a behavioural timer slave with programmable
// wait states; expected values are hand-computed from the slave memory image.
module tb_tmr_wb_master;
  import tmr_wb_master_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [1:0]  cmd;
  logic [2:0]  wadr;
  logic [7:0]  wdat;
  logic        busy, done, err;
  logic [31:0] data;
  logic [2:0]  wb_adr;
  logic [7:0]  wb_dat_o, wb_dat_i;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cyc, stb_cnt;
  logic        err_seen;
  logic [11:0] beat_q[$];

  logic [7:0]  mem [8];
  int          wait_n;
  logic        ack_en;
  int          wcnt;

  always #5 clk = ~clk;

  tmr_wb_master #(.TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .req_i    (req),
    .cmd_i    (cmd),
    .wadr_i   (wadr),
    .wdat_i   (wdat),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .data_o   (data),
    .wb_adr_o (wb_adr),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we_o  (wb_we),
    .wb_stb_o (wb_stb),
    .wb_cyc_o (wb_cyc),
    .wb_ack_i (wb_ack)
  );

  // Slave: combinational ack after wait_n stalled strobe cycles.
  always @(posedge clk) begin
    if (!wb_stb || wb_ack) wcnt <= 0;
    else                   wcnt <= wcnt + 1;
  end
  assign wb_ack   = ack_en && wb_stb && (wcnt == wait_n);
  assign wb_dat_i = wb_we ? 8'h00 : mem[wb_adr];

  always @(negedge clk) begin
    if (wb_stb && wb_ack) beat_q.push_back({wb_adr, wb_we, wb_dat_o});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command; cycle 1 is the first cycle after the accepting edge.
  task automatic run_cmd(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d,
                         input int budget, input int inj);
    int cyc;
    beat_q.delete();
    done_cyc = -1;
    stb_cnt  = 0;
    err_seen = 1'b0;
    @(negedge clk);
    cmd = c; wadr = a; wdat = d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    cyc = 0;
    while (cyc < budget && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      req = (cyc == inj);
      if (req) begin
        cmd = CMD_WR; wadr = 3'd5; wdat = 8'hAA;
      end
      if (wb_stb) stb_cnt++;
      if (done) begin
        done_cyc = cyc;
        err_seen = err;
      end
    end
    req = 1'b0;
  endtask

  task automatic chk_beats(input string tag, input int n, input logic [11:0] e0,
                           input logic [11:0] e1, input logic [11:0] e2, input logic [11:0] e3);
    logic [11:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, "_nbeats"}, 32'(beat_q.size()), 32'(n));
    for (int i = 0; i < n && i < beat_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(beat_q[i]), 32'(e[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; cmd = '0; wadr = '0; wdat = '0;
    wait_n = 0; ack_en = 1'b1;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;

    #1;
    chk("rst_outs", 32'({busy, done, err, wb_stb, wb_cyc, wb_we}), 32'd0);
    chk("rst_data", data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // µs read, zero wait, with a req pulse during the gap that must be ignored
    run_cmd(CMD_RD_US, 3'd0, 8'h00, 40, 2);
    chk("us_done_cyc", 32'(done_cyc), 32'd8);
    chk("us_err", 32'(err_seen), 32'd0);
    chk("us_data", data, 32'h44332211);
    chk("us_stb_cnt", 32'(stb_cnt), 32'd4);
    chk_beats("us", 4, 12'h000, 12'h200, 12'h400, 12'h600);
    @(negedge clk);
    chk("us_idle_after", 32'({busy, wb_cyc}), 32'd0);

    // ms read, two wait states per beat
    wait_n = 2;
    run_cmd(CMD_RD_MS, 3'd0, 8'h00, 60, -1);
    chk("ms_done_cyc", 32'(done_cyc), 32'd16);
    chk("ms_data", data, 32'h88776655);
    chk("ms_stb_cnt", 32'(stb_cnt), 32'd12);
    chk_beats("ms", 4, 12'h800, 12'hA00, 12'hC00, 12'hE00);

    // single byte write to PWM enable
    wait_n = 0;
    run_cmd(CMD_WR, PWM_ENA_ADR, 8'h3F, 20, -1);
    chk("wr_done_cyc", 32'(done_cyc), 32'd2);
    chk("wr_err", 32'(err_seen), 32'd0);
    chk("wr_data", data, 32'h88776655);
    chk_beats("wr", 1, 12'hD3F, 12'h0, 12'h0, 12'h0);

    // block delay: 300-cycle stall, far beyond TIMEOUT, must not abort
    wait_n = 299;
    run_cmd(CMD_BLK, 3'd0, 8'd10, 400, -1);
    chk("blk_stb_cnt", 32'(stb_cnt), 32'd300);
    chk("blk_done_cyc", 32'(done_cyc), 32'd301);
    chk("blk_err", 32'(err_seen), 32'd0);
    chk_beats("blk", 1, 12'hF0A, 12'h0, 12'h0, 12'h0);

    // read with a dead slave aborts after TIMEOUT+1 strobe cycles
    wait_n = 0; ack_en = 1'b0;
    run_cmd(CMD_RD_US, 3'd0, 8'h00, 20, -1);
    chk("tmo_stb_cnt", 32'(stb_cnt), 32'(TMO + 1));
    chk("tmo_done_cyc", 32'(done_cyc), 32'(TMO + 2));
    chk("tmo_err", 32'(err_seen), 32'd1);
    chk("tmo_data", data, 32'h88776655);
    chk_beats("tmo", 0, 12'h0, 12'h0, 12'h0, 12'h0);
    ack_en = 1'b1;

    run_cmd(CMD_RD_US, 3'd0, 8'h00, 40, -1);
    chk("post_tmo_done_cyc", 32'(done_cyc), 32'd8);
    chk("post_tmo_err", 32'(err_seen), 32'd0);
    chk("post_tmo_data", data, 32'h44332211);

    // asynchronous reset in the middle of a read
    @(negedge clk);
    cmd = CMD_RD_US; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_stb_before", 32'({wb_stb, wb_adr}), 32'({1'b1, 3'd1}));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus", 32'({wb_stb, wb_cyc, busy}), 32'd0);
    chk("rst_mid_data", data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
    run_cmd(CMD_RD_US, 3'd0, 8'h00, 40, -1);
    chk("post_rst_done_cyc", 32'(done_cyc), 32'd8);
    chk("post_rst_data", data, 32'hD4C3B2A1);
    chk_beats("post_rst", 4, 12'h000, 12'h200, 12'h400, 12'h600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_wb_master.md
# tmr_wb_master

8-bit WISHBONE master sequencer that drives the timer/PWM slave from the initiator side. A local command port requests a 32-bit µs or ms counter read, a single-byte register write, or a CPU-blocking µs delay. The block issues the required byte accesses in the order the slave needs: byte 0 first, which latches the upper bytes, then bytes 1..3. It sits between a small control FSM or debug bridge and the timer slave.

## Interface
Parameters:
- TIMEOUT, 255: maximum wait cycles with strobe high and no ack before a non-block access aborts; must be ≥1.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  command request; sampled only in IDLE.
- cmd_i  in  2  command: 00 read µs, 01 read ms, 10 write byte, 11 block delay.
- wadr_i  in  3  register address for write byte.
- wdat_i  in  8  write data, or delay in µs for block.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse, coincident with done_o, on timeout.
- data_o  out  32  last successfully read counter value.
- wb_adr_o  out  3  WISHBONE address.
- wb_dat_o  out  8  WISHBONE write data.
- wb_dat_i  in  8  WISHBONE read data.
- wb_we_o  out  1  write enable.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle; high from the first beat through the last beat of a command, including gaps.
- wb_ack_i  in  1  acknowledge; may be combinational from the slave.

## Operation
- FSM states: IDLE, STB, GAP, FIN.
- IDLE to STB on req_i=1. Latch cmd_i, wadr_i and wdat_i at that edge. Set beat index=0.
- Read commands:
  - base address 0 for µs, 4 for ms.
  - Beat i uses wb_adr_o=base+i, wb_we_o=0.
  - On ack, capture wb_dat_i into shadow byte i.
- Write byte: one beat with wb_adr_o=wadr_i, wb_we_o=1, wb_dat_o=wdat_i.
- Block delay: one beat with wb_adr_o=7, wb_we_o=1, wb_dat_o=wdat_i. The slave stalls ack for the delay. The timeout is disabled for this command.
- STB: wb_stb_o=1.
  - On ack with beats remaining, go to GAP.
  - On ack after the last beat, go to FIN.
  - On timeout, go to FIN with the error flag set.
- GAP: wb_stb_o=0 for one cycle, index+1, back to STB. Every beat is separated by at least one idle strobe cycle.
- FIN: done_o=1, busy_o=0, wb_cyc_o=0.
  - Read without error: data_o updates at this cycle.
  - On error, err_o=1 and data_o is unchanged.
  - Unconditional return to IDLE. A req_i sampled in FIN is accepted as if in IDLE.
- A req_i arriving while in STB or GAP is ignored and not queued.
- Timeout counter: width $clog2(TIMEOUT+1). Cleared on entering STB, increments each STB cycle without ack. Abort when count==TIMEOUT.
- wb_dat_o=0 during reads.

## Timing
- Reset value of every output is 0. Reset takes effect asynchronously: strobe and cycle drop immediately and the FSM goes to IDLE.
- Reset mid-command discards shadow bytes; data_o returns to 0.
- Read, zero-wait slave: request accepted at edge 0.
  - Strobe is high in cycles 1, 3, 5, 7.
  - done_o and the new data_o appear in cycle 8.
- Write, zero-wait: strobe in cycle 1, done_o in cycle 2.
- Wait states: each extra cycle without ack extends strobe by one cycle and shifts all later events by one.
- Ack with wb_stb_o=0 is ignored.
- Timeout abort: strobe stays high for TIMEOUT+1 cycles; done_o and err_o assert in the next cycle.

## Structure
- Shared package holds:
  - command codes CMD_RD_US=2'b00, CMD_RD_MS=2'b01, CMD_WR=2'b10, CMD_BLK=2'b11;
  - addresses US_BASE=3'd0, MS_BASE=3'd4, BLK_ADR=3'd7, PWM_ENA_ADR=3'd6;
  - FSM state encodings.
- One sub-module: wb8_beat. It runs a single strobe/ack beat with timeout and reports ack or timeout to the parent. The command sequencer, beat index and shadow register stay in the parent.

## Test plan
- Read µs, zero-wait slave returns 0x11, 0x22, 0x33, 0x44 -> addresses 0, 1, 2, 3 with we=0; data_o=0x44332211; done_o in cycle 8; err_o=0.
- Read ms with 2 wait states per beat -> addresses 4..7; done_o in cycle 16; data_o is the assembled ms value.
- Write byte, wadr_i=6, wdat_i=0x3F -> one beat with adr=6, we=1, dat=0x3F; done_o in cycle 2; data_o unchanged.
- Block delay, wdat_i=10, slave acks after 300 cycles -> strobe held 300 cycles; no err_o; done_o the cycle after ack.
- Read with ack never asserted, TIMEOUT=4 -> strobe high 5 cycles; then done_o=err_o=1 together; data_o unchanged; next req_i accepted.
- Reset asserted during beat 2 of a read -> stb/cyc go low and busy_o=0 without a clock edge; data_o=0; a following read starts at address 0 and completes correctly.
